// File: rtl/ram_rd_streamer_pkg.sv
// Shared types and defaults for the RAM read streamer.
package ram_rd_streamer_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned CNT_W      = DEF_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_rd_fifo.sv
// Show-ahead FIFO: pop_data always presents the oldest entry.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module ram_rd_fifo #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               push,
    input  logic [DATA_W-1:0]                  push_data,
    input  logic                               pop,
    output logic [DATA_W-1:0]                  pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               full,
    output logic                               empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == OCC_W'(FIFO_DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage updates for this edge
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_rd_streamer.sv
// Burst read initiator for the dual_port_ram read port, streaming beats on
// a valid/ready interface. Reads are only issued while buffer credit exists,
// so every in-flight RAM word always has a FIFO slot waiting for it.
// Optional feature macro: RAM_RD_STREAMER_LAST_EN adds the m_last output.
module ram_rd_streamer
    import ram_rd_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rd,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef RAM_RD_STREAMER_LAST_EN
    ,
    output logic              m_last
`endif
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = OCC_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] rd_add_q, rd_add_d;
    logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [OCC_W-1:0]  inflight_q, inflight_d;
`ifdef RAM_RD_STREAMER_LAST_EN
    logic [LEN_W-1:0]  left_q, left_d;
`endif

    logic              issue;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic              drain_done;
    logic [OCC_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign push      = vld_sr_q[RD_LAT-1];
    assign pop       = !fifo_empty && m_ready;
    assign m_valid   = !fifo_empty;
    assign rd        = rd_q;
    assign rd_add    = rd_add_q;
    assign credit_ok = (CRD_W'(fifo_count) + CRD_W'(inflight_q)) < CRD_W'(FIFO_DEPTH);
    assign issue     = (state_q == ISSUE) && (remain_q != '0) && credit_ok;

    // Leave DRAIN on the edge that pops the last buffered beat so done
    // appears in the very next cycle.
    assign drain_done = (inflight_q == '0) &&
                        (fifo_empty || ((fifo_count == OCC_W'(1)) && pop));

`ifdef RAM_RD_STREAMER_LAST_EN
    assign m_last = !fifo_empty && (left_q == LEN_W'(1));
`endif

    ram_rd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (out),
        .pop       (pop),
        .pop_data  (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (remain_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        busy = (state_q == ISSUE) || (state_q == DRAIN);
        done = (state_q == FIN);
    end

    // Read issue, address/count bookkeeping and in-flight tracking
    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        rd_d     = issue;
        rd_add_d = rd_add_q;
        if ((state_q == IDLE) && start) begin
            addr_d   = base_addr;
            remain_d = length;
        end else if (issue) begin
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            rd_add_d = addr_q;
        end

        vld_sr_d    = vld_sr_q;
        vld_sr_d[0] = rd_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        inflight_d = inflight_q + OCC_W'(issue) - OCC_W'(push);
    end

`ifdef RAM_RD_STREAMER_LAST_EN
    // Beats still to be delivered, used to flag the final beat
    always_comb begin
        left_d = left_q;
        if ((state_q == IDLE) && start) begin
            left_d = length;
        end else if (pop && (left_q != '0)) begin
            left_d = left_q - 1'b1;
        end
    end
`endif

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            remain_q   <= '0;
            rd_q       <= 1'b0;
            rd_add_q   <= '0;
            vld_sr_q   <= '0;
            inflight_q <= '0;
`ifdef RAM_RD_STREAMER_LAST_EN
            left_q     <= '0;
`endif
        end else begin
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_q       <= rd_d;
            rd_add_q   <= rd_add_d;
            vld_sr_q   <= vld_sr_d;
            inflight_q <= inflight_d;
`ifdef RAM_RD_STREAMER_LAST_EN
            left_q     <= left_d;
`endif
        end
    end

    // A capture must never arrive at a full FIFO unless a pop frees a slot
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_ram_rd_streamer.sv
module tb_ram_rd_streamer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] length = '0;
    logic        m_ready = 1'b0;
    logic        busy, done, rd, m_valid;
    logic [11:0] rd_add;
    logic [63:0] m_data;
    logic [63:0] ram_out = '0;
`ifdef RAM_RD_STREAMER_LAST_EN
    logic        m_last;
`endif

    logic [63:0] mem [0:4095];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;

    ram_rd_streamer dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd        (rd),
        .rd_add    (rd_add),
        .out       (ram_out),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
`ifdef RAM_RD_STREAMER_LAST_EN
        ,
        .m_last    (m_last)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM read port, one edge of latency
    always @(posedge clk) if (rd) ram_out <= mem[rd_add];

    function automatic logic [63:0] ram_word(input logic [11:0] a);
        logic [31:0] h;
        h = {20'h0, a} * 32'h9E3779B9;
        return {h ^ 32'hC0FFEE00, 20'h0, a};
    endfunction

    function automatic logic [11:0] addr_at(input logic [11:0] b, input int i);
        return 12'((int'(b) + i) % 4096);
    endfunction

    // Monitor
    logic [63:0] got_q[$];
    logic        got_last_q[$];
    logic [11:0] rda_q[$];
    int          pop_cyc_q[$];
    int rd_cnt, pop_cnt, done_cnt, busy_cnt, valid_cnt, max_out;
    int first_valid_cyc, done_cyc, stall_rd_cnt;
    logic stall_win = 1'b0;

    always @(negedge clk) begin
        if (resetn) begin
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid) valid_cnt++;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (rd) begin
                rd_cnt++;
                rda_q.push_back(rd_add);
                if (stall_win) stall_rd_cnt++;
            end
            if (rd_cnt - pop_cnt > max_out) max_out = rd_cnt - pop_cnt;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                pop_cyc_q.push_back(cyc);
`ifdef RAM_RD_STREAMER_LAST_EN
                got_last_q.push_back(m_last);
`else
                got_last_q.push_back(1'b0);
`endif
                pop_cnt++;
            end
        end
    end

    task automatic clear_mon();
        got_q.delete(); got_last_q.delete(); rda_q.delete(); pop_cyc_q.delete();
        rd_cnt = 0; pop_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        max_out = 0; first_valid_cyc = -1; done_cyc = -1; stall_rd_cnt = 0;
    endtask

    // mode 0: always ready, 1: stall cycles 3..12, 2: random ready,
    // 3: always ready plus a second start at cycle 5
    task automatic run_burst(input logic [11:0] b, input logic [12:0] n,
                             input int mode, input int budget, output bit timed_out);
        clear_mon();
        @(posedge clk); #1;
        base_addr = b; length = n; start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            case (mode)
                1: m_ready = !(k >= 3 && k <= 12);
                2: m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b1;
            endcase
            stall_win = (mode == 1) && (k >= 8) && (k <= 12);
            if (mode == 3) begin
                start     = (k == 5);
                base_addr = (k == 5) ? b + 12'h200 : b;
                length    = (k == 5) ? 13'd3 : n;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) begin timed_out = 1'b0; break; end
        end
        start = 1'b0; stall_win = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL burst_timeout base=%h len=%0d: done not seen within %0d cycles", b, n, budget);
        end
    endtask

    task automatic check_stream(input string tag, input logic [11:0] b, input int n);
        n_checks++;
        if (got_q.size() !== n) begin
            n_fail++;
            $display("FAIL %s_beat_count: got %0d required %0d", tag, got_q.size(), n);
        end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== ram_word(addr_at(b, i))) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got %h required %h", tag, i, got_q[i], ram_word(addr_at(b, i)));
            end
`ifdef RAM_RD_STREAMER_LAST_EN
            n_checks++;
            if (got_last_q[i] !== (i == n - 1)) begin
                n_fail++;
                $display("FAIL %s_m_last[%0d]: got %b required %b", tag, i, got_last_q[i], (i == n - 1));
            end
`endif
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s_done_pulses: got %0d required 1", tag, done_cnt);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_after: got %b required 0", tag, busy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({rd, rd_add, m_valid, m_data, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL %s: got rd=%b rd_add=%h m_valid=%b m_data=%h busy=%b done=%b required all zero",
                     tag, rd, rd_add, m_valid, m_data, busy, done);
        end
`ifdef RAM_RD_STREAMER_LAST_EN
        n_checks++;
        if (m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_m_last: got %b required 0", tag, m_last);
        end
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        run_burst(12'h010, 13'd4, 0, 60, to);
        check_stream("basic", 12'h010, 4);
        n_checks++;
        if (rd_cnt !== 4) begin
            n_fail++;
            $display("FAIL basic_rd_pulses: got %0d required 4", rd_cnt);
        end
        n_checks++;
        if (first_valid_cyc !== t0 + 3) begin
            n_fail++;
            $display("FAIL basic_latency: m_valid first at cycle %0d required %0d", first_valid_cyc, t0 + 3);
        end
        for (int i = 1; i < pop_cyc_q.size(); i++) begin
            n_checks++;
            if (pop_cyc_q[i] !== pop_cyc_q[i-1] + 1) begin
                n_fail++;
                $display("FAIL basic_consecutive[%0d]: cycle %0d required %0d", i, pop_cyc_q[i], pop_cyc_q[i-1] + 1);
            end
        end
        if (pop_cyc_q.size() > 0) begin
            n_checks++;
            if (done_cyc !== pop_cyc_q[pop_cyc_q.size()-1] + 1) begin
                n_fail++;
                $display("FAIL basic_done_timing: done at cycle %0d required %0d",
                         done_cyc, pop_cyc_q[pop_cyc_q.size()-1] + 1);
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        run_burst(12'hFFE, 13'd4, 0, 60, to);
        check_stream("wrap", 12'hFFE, 4);
        n_checks++;
        if (rda_q.size() !== 4) begin
            n_fail++;
            $display("FAIL wrap_rd_count: got %0d required 4", rda_q.size());
        end
        for (int i = 0; i < 4 && i < rda_q.size(); i++) begin
            n_checks++;
            if (rda_q[i] !== addr_at(12'hFFE, i)) begin
                n_fail++;
                $display("FAIL wrap_rd_add[%0d]: got %h required %h", i, rda_q[i], addr_at(12'hFFE, i));
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        run_burst(12'h300, 13'd16, 1, 200, to);
        check_stream("backpressure", 12'h300, 16);
        n_checks++;
        if (max_out > DEPTH) begin
            n_fail++;
            $display("FAIL backpressure_outstanding: got %0d required <= %0d", max_out, DEPTH);
        end
        n_checks++;
        if (stall_rd_cnt !== 0) begin
            n_fail++;
            $display("FAIL backpressure_rd_stalled: got %0d reads required 0", stall_rd_cnt);
        end
    endtask

    task automatic test_zero_length();
        bit to;
        run_burst(12'h055, 13'd0, 0, 20, to);
        n_checks++;
        if (rd_cnt !== 0 || valid_cnt !== 0) begin
            n_fail++;
            $display("FAIL zero_len_activity: rd=%0d valid=%0d required 0/0", rd_cnt, valid_cnt);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_len_done: got %0d required 1", done_cnt);
        end
        n_checks++;
        if (busy_cnt !== 0) begin
            n_fail++;
            $display("FAIL zero_len_busy: busy seen %0d cycles required 0", busy_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        bit reached = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        base_addr = 12'h040; length = 13'd8; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (got_q.size() >= 3) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL midreset_reach: got %0d beats required 3", got_q.size());
        end
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset_values");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        run_burst(12'h100, 13'd2, 0, 40, to);
        check_stream("midreset_new", 12'h100, 2);
        n_checks++;
        if (rd_cnt !== 2) begin
            n_fail++;
            $display("FAIL midreset_rd_pulses: got %0d required 2", rd_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        run_burst(12'h7F0, 13'd16, 3, 120, to);
        check_stream("start_busy", 12'h7F0, 16);
    endtask

    task automatic test_random();
        bit to;
        logic [11:0] b;
        int n;
        for (int r = 0; r < 6; r++) begin
            b = 12'($urandom_range(0, 4095));
            n = $urandom_range(1, 40);
            run_burst(b, 13'(n), 2, n * 12 + 60, to);
            check_stream("random", b, n);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = ram_word(12'(a));
        clear_mon();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_reset_mid_burst();
        test_start_while_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
- Read-side initiator for the dual_port_ram read port. It drives rd/rd_add and captures the RAM's out data.
- Converts a single burst command (base address, length) into a stream of 64-bit beats on a valid/ready output.
- A small internal FIFO absorbs downstream backpressure. Sits between the RAM read port and any consumer (DMA, checker, packetiser).

Parameters:
ADDR_W, 12, RAM address width (depth 2**ADDR_W)
DATA_W, 64, RAM data width
RD_LAT, 1, RAM read latency in clock edges from the edge sampling rd=1 to the edge where out is valid
FIFO_DEPTH, 4, output buffer entries; power of 2, >= RD_LAT+2

Ports:
clk  input  1  clock, all logic on posedge
resetn  input  1  asynchronous active-low reset
start  input  1  burst command strobe, accepted only in IDLE
base_addr  input  ADDR_W  first read address
length  input  ADDR_W+1  beat count, 0..4096
busy  output  1  burst in progress
done  output  1  one-cycle pulse when burst fully delivered
rd  output  1  RAM read enable (registered)
rd_add  output  ADDR_W  RAM read address (registered)
out  input  DATA_W  RAM read data
m_data  output  DATA_W  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready

Behaviour:
- Reset values (async on resetn low): rd=0, rd_add=0, m_valid=0, m_data=0, busy=0, done=0, FIFO empty, in-flight tracker cleared, state=IDLE.
- Reset mid-burst discards all in-flight RAM data. No stale beat is ever presented after reset release.
- States:
  - IDLE: start=1 latches base_addr and length, then moves to ISSUE. If length=0, moves to FIN instead.
  - ISSUE: reads are issued until the remaining count reaches 0, then moves to DRAIN.
  - DRAIN: waits until in-flight=0 and the FIFO is empty, then moves to FIN.
  - FIN: done=1 for one cycle, then returns to IDLE.
- busy=1 in ISSUE and DRAIN, 0 in IDLE and FIN. start is ignored whenever the state is not IDLE.
- Issue rule: in ISSUE, a read is issued at a clock edge (rd=1 and rd_add=current addr appear after that edge) only if remaining>0 and fifo_count+inflight < FIFO_DEPTH. Otherwise rd=0 in that cycle.
- Address increments modulo 2**ADDR_W: 0xFFF wraps to 0x000.
- Capture: a valid shift register of RD_LAT stages tracks issued reads. At the edge where a tag exits it, out is pushed into the FIFO. Credit accounting guarantees the FIFO never overflows.
- m_valid = FIFO non-empty; m_data = FIFO head (show-ahead).
- A pop occurs on m_valid && m_ready at the edge. Simultaneous push and pop on a full FIFO is legal and keeps the count unchanged.
- Latency with RD_LAT=1, start sampled at edge 0:
  - rd high after edge 1;
  - RAM samples at edge 2;
  - m_valid high after edge 3.
- Throughput: 1 beat/cycle sustained while m_ready=1.
- Ordering: beats are delivered in address order. No beat is dropped or duplicated under any m_ready pattern.
- done rises in the cycle after the edge that pops the final beat.

Optional Feature:
RAM_RD_STREAMER_LAST_EN
- Defined: adds output m_last (1 bit, reset 0). m_last=1 together with m_valid on the final beat of the burst only, and is held stable under backpressure.
- Undefined: the port does not exist. Consumers count beats themselves.

Decomposition:
- Package ram_rd_streamer_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, FIN);
  - the ADDR_W/DATA_W defaults;
  - localparam CNT_W = ADDR_W+1.
- Sub-module ram_rd_fifo: synchronous show-ahead FIFO with parameters DATA_W and FIFO_DEPTH; ports push, pop, count, full, empty; async active-low reset.

Test Plan:
- Basic burst: RAM preloaded mem[a]=a; base_addr=0x010, length=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, exactly 4 rd pulses, single done pulse, busy low afterwards.
- Wrap: base_addr=0xFFE, length=4 -> rd_add sequence 0xFFE,0xFFF,0x000,0x001; data in that order.
- Backpressure: length=16, m_ready=0 for cycles 3..12 -> at most FIFO_DEPTH reads outstanding, rd=0 while stalled, all 16 values delivered in order after m_ready=1.
- Zero length: start with length=0 -> rd never asserted, m_valid never asserted, done pulses once, busy stays 0.
- Reset mid-burst: length=8, resetn low after 3 beats delivered -> all outputs at reset values. A new burst base_addr=0x100, length=2 then delivers only 0x100,0x101.
- Start while busy: second start during a 16-beat burst -> ignored, exactly 16 beats. With RAM_RD_STREAMER_LAST_EN defined, m_last=1 on beat 16 only.
